// File: rtl/bcd_display_scan.sv
// bcd_display_scan: holds a two-digit BCD product and scans it onto a shared 7-segment bus
module bcd_display_scan #(
    parameter int REFRESH_DIV = 4,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bcd_in,
    input  logic       load,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);
    logic [7:0]       r_hold;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sel;
    logic [6:0]       r_seg;
    logic [1:0]       r_an;
    logic [3:0]       w_digit;
    logic [6:0]       w_dec;
    logic             w_blank;
    logic             w_wrap;

    assign w_digit = r_sel ? r_hold[7:4] : r_hold[3:0];
    assign w_blank = r_sel & blank_lz & (r_hold[7:4] == 4'd0);
    assign w_wrap  = (r_cnt == CNT_W'(REFRESH_DIV - 1));

    // seven-segment decode of the selected digit; any non-BCD nibble shows a dash
    always_comb begin
        w_dec = 7'h40;
        case (w_digit)
            4'd0: w_dec = 7'h3F;
            4'd1: w_dec = 7'h06;
            4'd2: w_dec = 7'h5B;
            4'd3: w_dec = 7'h4F;
            4'd4: w_dec = 7'h66;
            4'd5: w_dec = 7'h6D;
            4'd6: w_dec = 7'h7D;
            4'd7: w_dec = 7'h07;
            4'd8: w_dec = 7'h7F;
            4'd9: w_dec = 7'h6F;
            default: w_dec = 7'h40;
        endcase
    end

    // capture the product on load and flag any nibble above 9 in the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= 8'h00;
            r_err  <= 1'b0;
        end else if (load) begin
            r_hold <= bcd_in;
            r_err  <= (bcd_in[7:4] > 4'd9) | (bcd_in[3:0] > 4'd9);
        end
    end

    // free-running refresh counter; flips the digit select every REFRESH_DIV edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_sel <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_sel <= ~r_sel;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // register segment and anode drive from one sel/hold sample so digits never mix
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= 7'h00;
            r_an  <= 2'b00;
        end else begin
            r_seg <= w_blank ? 7'h00 : w_dec;
            r_an  <= w_blank ? 2'b00 : (r_sel ? 2'b10 : 2'b01);
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign err = r_err;
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: directed and random checks of bcd_display_scan against a timeline model
module tb_bcd_display_scan;
    localparam int DIV = 4;
    localparam logic [6:0] DEC [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] bcd_in = 8'h00;
    logic       load = 1'b0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    int checks = 0;
    int failures = 0;

    // model: held value, error flag and count of edges since reset release
    logic [7:0] m_hold = 8'h00;
    logic       m_err = 1'b0;
    int         m_p = 0;
    logic [6:0] e_seg = 7'h00;
    logic [1:0] e_an = 2'b00;

    bcd_display_scan #(.REFRESH_DIV(DIV), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
        .blank_lz(blank_lz), .seg(seg), .an(an), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input logic [3:0] n);
        return (n > 4'd9) ? 7'h40 : DEC[n];
    endfunction

    task automatic check(input string tag);
        checks += 3;
        assert (seg === e_seg) else begin
            failures++;
            $error("FAIL %s seg observed=%h expected=%h", tag, seg, e_seg);
        end
        assert (an === e_an) else begin
            failures++;
            $error("FAIL %s an observed=%b expected=%b", tag, an, e_an);
        end
        assert (err === m_err) else begin
            failures++;
            $error("FAIL %s err observed=%b expected=%b", tag, err, m_err);
        end
    endtask

    // one clock edge: tens are shown in every odd block of DIV edges since release
    task automatic tick(input logic ld, input logic [7:0] d, input logic bl, input string tag);
        logic       tens;
        logic [3:0] dig;
        logic       blank;
        load = ld;
        bcd_in = d;
        blank_lz = bl;
        @(posedge clk);
        tens  = ((m_p / DIV) % 2) == 1;
        dig   = tens ? m_hold[7:4] : m_hold[3:0];
        blank = tens && bl && (m_hold[7:4] == 4'd0);
        e_seg = blank ? 7'h00 : dec(dig);
        e_an  = blank ? 2'b00 : (tens ? 2'b10 : 2'b01);
        if (ld) begin
            m_hold = d;
            m_err  = (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
        end
        m_p++;
        #1 check(tag);
    endtask

    task automatic idle(input int n, input logic bl, input string tag);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, bl, tag);
    endtask

    task automatic model_reset();
        m_hold = 8'h00;
        m_err  = 1'b0;
        m_p    = 0;
        e_seg  = 7'h00;
        e_an   = 2'b00;
    endtask

    initial begin
        #12 check("reset");
        #10 rst_n = 1'b1;
        tick(1'b0, 8'h00, 1'b0, "first_edge");
        checks++;
        assert (seg === 7'h3F && an === 2'b01) else begin
            failures++;
            $error("FAIL first_edge_direct observed=%h/%b expected=3f/01", seg, an);
        end
        idle(2, 1'b0, "post_reset");
        tick(1'b1, 8'h72, 1'b0, "load_72");
        idle(2 * DIV + 3, 1'b0, "show_72");
        tick(1'b1, 8'h08, 1'b1, "load_08");
        idle(2 * DIV + 2, 1'b1, "show_08_blank");
        idle(2 * DIV, 1'b0, "show_08_noblank");
        tick(1'b1, 8'h1C, 1'b1, "load_1c");
        idle(2 * DIV, 1'b1, "show_1c");
        tick(1'b1, 8'h25, 1'b1, "load_25");
        idle(2 * DIV, 1'b1, "show_25");
        tick(1'b1, 8'h00, 1'b1, "load_00");
        idle(2 * DIV, 1'b1, "show_00");
        tick(1'b1, 8'h37, 1'b0, "load_37");
        while ((m_p % (2 * DIV)) != DIV - 1) tick(1'b0, 8'h00, 1'b0, "align_toggle");
        tick(1'b1, 8'h81, 1'b0, "load_at_toggle");
        tick(1'b0, 8'h00, 1'b0, "after_toggle");
        checks++;
        assert (seg === 7'h7F && an === 2'b10) else begin
            failures++;
            $error("FAIL toggle_direct observed=%h/%b expected=7f/10", seg, an);
        end
        idle(DIV, 1'b0, "after_toggle_run");
        while (((m_p / DIV) % 2) != 1) tick(1'b0, 8'h00, 1'b0, "seek_tens");
        tick(1'b0, 8'h00, 1'b0, "tens_before_reset");
        #1 rst_n = 1'b0;
        model_reset();
        #1 check("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1 check("held_in_reset");
        #2 rst_n = 1'b1;
        tick(1'b0, 8'h00, 1'b0, "restart");
        for (int i = 0; i < 400; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 7) == 0) ? 8'($urandom) :
                {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 3) == 0) d[7:4] = 4'd0;
            tick($urandom_range(0, 4) == 0, d, 1'($urandom), "random");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
